// File: rtl/mult_div.sv
// Multi-cycle integer multiply/divide unit for the EX stage.
// It computes a single-cycle registered 64-bit product, or a 32-step restoring divide that yields {remainder, quotient}.
module mult_div (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  funct,
  input  logic [31:0] operand_1,
  input  logic [31:0] operand_2,
  input  logic        stall_in,
  input  logic        flush,
  output logic        mult_div_done,
  output logic [63:0] mult_div_result
);

  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] DIV_LAST = 6'd32;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [5:0]  r_count;
  logic [63:0] r_result;

  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic        r_signed;
  logic [31:0] r_quot;
  logic [31:0] r_rem;
  logic [31:0] r_divisor;
  logic        r_q_neg;
  logic        r_r_neg;
  logic        r_div_zero;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_signed;
  logic        w_start_mul;
  logic        w_start_div;
  logic        w_div_busy;
  logic        w_div_finish;
  logic        w_op1_neg;
  logic        w_op2_neg;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_product;
  logic [32:0] w_rem_shift;
  logic [32:0] w_rem_sub;
  logic        w_ge;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;

  assign w_is_mul    = (funct == FN_MULT) || (funct == FN_MULTU);
  assign w_is_div    = (funct == FN_DIV)  || (funct == FN_DIVU);
  assign w_signed    = (funct == FN_MULT) || (funct == FN_DIV);
  assign w_start_mul = (r_state == S_IDLE) && !flush && w_is_mul;
  assign w_start_div = (r_state == S_IDLE) && !flush && w_is_div;
  assign w_div_busy   = (r_state == S_DIV) && (r_count != DIV_LAST);
  assign w_div_finish = (r_state == S_DIV) && (r_count == DIV_LAST);

  assign w_op1_neg = w_signed & operand_1[31];
  assign w_op2_neg = w_signed & operand_2[31];
  assign w_abs1    = w_op1_neg ? (~operand_1 + 32'd1) : operand_1;
  assign w_abs2    = w_op2_neg ? (~operand_2 + 32'd1) : operand_2;

  // One 64x64 multiplier serves both forms; the low 64 bits are exact for either extension.
  assign w_mul_a   = r_signed ? {{32{r_op1[31]}}, r_op1} : {32'd0, r_op1};
  assign w_mul_b   = r_signed ? {{32{r_op2[31]}}, r_op2} : {32'd0, r_op2};
  assign w_product = w_mul_a * w_mul_b;

  // Partial remainder stays below 2*divisor, so bit 32 of the difference is a clean borrow flag.
  assign w_rem_shift = {r_rem, r_quot[31]};
  assign w_rem_sub   = w_rem_shift - {1'b0, r_divisor};
  assign w_ge        = ~w_rem_sub[32];

  assign w_quot_fix = r_q_neg ? (~r_quot + 32'd1) : r_quot;
  assign w_rem_fix  = r_r_neg ? (~r_rem + 32'd1) : r_rem;

  always_comb begin
    // NOTE: default first so every path assigns w_state_next and no latch is inferred.
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_is_mul)      w_state_next = S_MUL;
          else if (w_is_div) w_state_next = S_DIV;
        end
        S_MUL:  w_state_next = S_DONE;
        S_DIV:  if (r_count == DIV_LAST) w_state_next = S_DONE;
        S_DONE: if (!stall_in) w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_count  <= 6'd0;
      r_result <= 64'h0;
    end else begin
      r_state <= w_state_next;
      if (w_start_div)
        r_count <= 6'd0;
      else if (w_div_busy && !flush)
        r_count <= r_count + 6'd1;
      if (!flush) begin
        if (r_state == S_MUL)
          r_result <= w_product;
        else if (w_div_finish)
          r_result <= r_div_zero ? {r_op1, 32'hFFFF_FFFF} : {w_rem_fix, w_quot_fix};
      end
    end
  end

  // NOTE: datapath registers are not reset; they are always loaded in the start cycle before use.
  always_ff @(posedge clk) begin
    if (w_start_mul || w_start_div) begin
      r_op1    <= operand_1;
      r_op2    <= operand_2;
      r_signed <= w_signed;
    end
    if (w_start_div) begin
      r_quot     <= w_abs1;
      r_divisor  <= w_abs2;
      r_rem      <= 32'd0;
      r_q_neg    <= w_op1_neg ^ w_op2_neg;
      r_r_neg    <= w_op1_neg;
      r_div_zero <= (operand_2 == 32'd0);
    end else if (w_div_busy) begin
      r_quot <= {r_quot[30:0], w_ge};
      r_rem  <= w_ge ? w_rem_sub[31:0] : w_rem_shift[31:0];
    end
  end

  assign mult_div_done   = (r_state == S_DONE);
  assign mult_div_result = r_result;

endmodule

// File: tb/tb_mult_div.sv
// Directed bench for mult_div: vector table for latency/results, plus hand sequences for stall, flush, back-to-back and reset.
module tb_mult_div;

  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  funct;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        stall_in;
  logic        flush;
  logic        mult_div_done;
  logic [63:0] mult_div_result;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mult_div dut (
    .clk             (clk),
    .rst             (rst),
    .funct           (funct),
    .operand_1       (operand_1),
    .operand_2       (operand_2),
    .stall_in        (stall_in),
    .flush           (flush),
    .mult_div_done   (mult_div_done),
    .mult_div_result (mult_div_result)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE, disturb the inputs while it runs, measure latency, then retire it.
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int lat, input string name);
    int n;
    funct     = f;
    operand_1 = a;
    operand_2 = b;
    tick();
    funct     = f ^ 6'h01;
    operand_1 = ~a;
    operand_2 = a ^ b ^ 32'h0000_0001;
    n = 1;
    while (n < 60 && mult_div_done !== 1'b1) begin
      tick();
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(lat));
    check({name, " result"}, mult_div_result, exp);
    funct = 6'h00;
    tick();
    check({name, " idle after"}, {63'd0, mult_div_done}, 64'd0);
  endtask

  initial begin
    vec_t vecs[13];
    int   seen;

    vecs[0]  = '{FN_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 2};
    vecs[1]  = '{FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 2};
    vecs[2]  = '{FN_MULT,  32'hFFFF_FFFF, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFFB, 2};
    vecs[3]  = '{FN_MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 2};
    vecs[4]  = '{FN_DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E, 34};
    vecs[5]  = '{FN_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 34};
    vecs[6]  = '{FN_DIVU,  32'h1234_5678, 32'd0,         64'h1234_5678_FFFF_FFFF, 34};
    vecs[7]  = '{FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 34};
    vecs[8]  = '{FN_DIV,   32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_FFFF_FFFF, 34};
    vecs[9]  = '{FN_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 34};
    vecs[10] = '{FN_DIVU,  32'hFFFF_FFFF, 32'd10,        64'h0000_0005_1999_9999, 34};
    vecs[11] = '{FN_DIVU,  32'd5,         32'd9,         64'h0000_0005_0000_0000, 34};
    vecs[12] = '{FN_MULT,  32'd7,         32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2, 2};

    rst       = 1'b1;
    funct     = 6'h00;
    operand_1 = 32'd0;
    operand_2 = 32'd0;
    stall_in  = 1'b0;
    flush     = 1'b0;
    repeat (3) tick();
    check("reset done", {63'd0, mult_div_done}, 64'd0);
    check("reset result", mult_div_result, 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++)
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

    // Stall held in DONE for three cycles: done and result hold for four cycles.
    funct = FN_MULTU; operand_1 = 32'd3; operand_2 = 32'd4;
    tick();
    tick();
    check("stall d1 done", {63'd0, mult_div_done}, 64'd1);
    check("stall d1 result", mult_div_result, 64'd12);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      operand_1 = 32'h5555_0000 + 32'(i);
      tick();
      check($sformatf("stall d%0d done", i + 2), {63'd0, mult_div_done}, 64'd1);
      check($sformatf("stall d%0d result", i + 2), mult_div_result, 64'd12);
    end
    stall_in = 1'b0;
    funct    = 6'h00;
    tick();
    check("stall release idle", {63'd0, mult_div_done}, 64'd0);
    tick();
    check("stall no restart", {63'd0, mult_div_done}, 64'd0);

    // Flush at divide iteration 10, then a fresh MULT two cycles later.
    funct = FN_DIVU; operand_1 = 32'd100; operand_2 = 32'd7;
    tick();
    repeat (10) tick();
    flush = 1'b1;
    tick();
    check("flush done low", {63'd0, mult_div_done}, 64'd0);
    check("flush result held", mult_div_result, 64'd12);
    flush = 1'b0;
    funct = 6'h00;
    tick();
    tick();
    check("flush stays idle", {63'd0, mult_div_done}, 64'd0);
    run_op(FN_MULT, 32'hFFFF_FFFD, 32'd6, 64'hFFFF_FFFF_FFFF_FFEE, 2, "post-flush mult");

    // Back-to-back MULTs: the second one is taken in the IDLE cycle after DONE.
    funct = FN_MULT; operand_1 = 32'd2; operand_2 = 32'd3;
    tick();
    tick();
    check("b2b first done", {63'd0, mult_div_done}, 64'd1);
    check("b2b first result", mult_div_result, 64'd6);
    operand_1 = 32'd5; operand_2 = 32'd7;
    tick();
    check("b2b gap idle", {63'd0, mult_div_done}, 64'd0);
    tick();
    check("b2b gap mul", {63'd0, mult_div_done}, 64'd0);
    tick();
    check("b2b second done", {63'd0, mult_div_done}, 64'd1);
    check("b2b second result", mult_div_result, 64'd35);
    funct = 6'h00;
    tick();
    check("b2b idle after", {63'd0, mult_div_done}, 64'd0);

    // Reset in the middle of a divide abandons it.
    funct = FN_DIV; operand_1 = 32'd100; operand_2 = 32'd7;
    tick();
    repeat (5) tick();
    rst   = 1'b1;
    funct = 6'h00;
    tick();
    rst = 1'b0;
    check("rst mid-div done", {63'd0, mult_div_done}, 64'd0);
    check("rst mid-div result", mult_div_result, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mult_div_done === 1'b1) seen++;
    end
    check("rst mid-div no done", 64'(seen), 64'd0);
    check("rst mid-div result later", mult_div_result, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
